midi_oscillator: RTL and testbench
==================================

MIDI_OSCILLATOR -- requirements
Module: midi_oscillator

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter PHASE_W, default 32, phase accumulator width in bits.
REQ-003 Parameter OUT_W, default 24, signed output sample width in bits.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port note_valid  input  1  single-cycle strobe; loads note when busy=0.
REQ-007 Port note  input  7  MIDI note number, 0..127.
REQ-008 Port gate  input  1  note-on; 0 silences the output and holds phase at 0.
REQ-009 Port volume  input  7  unsigned amplitude, 0..127.
REQ-010 Port mode  input  2  waveform: 0 SQUARE, 1 SAW, 2 TRIANGLE, 3 PULSE.
REQ-011 Port duty  input  7  PULSE high fraction, duty/128 of period.
REQ-012 Port busy  output  1  high while a note-to-increment conversion is in progress.
REQ-013 Port value  output  OUT_W  signed two's-complement sample.

Function
REQ-014 inc SHALL equal TOP_INC[s] >> (10 - o), where o = note/12 and s = note%12; TOP_INC[s] = round(440 * 2^((120+s-69)/12) * 2^PHASE_W / CLK_HZ), evaluated at elaboration.
REQ-015 Converter FSM: IDLE -> DIV on note_valid && !busy; latch note; set o=0, r=note.
REQ-016 DIV: while r >= 12, r -= 12 and o += 1, one step per cycle; when r < 12, go to LOAD.
REQ-017 LOAD: inc <= TOP_INC[r] >> (10 - o), then return to IDLE; busy=1 in DIV and LOAD only.
REQ-018 Latency from note_valid to inc update SHALL be o+2 cycles (note 69: 7 cycles; note 127: 12 cycles).
REQ-019 note_valid while busy=1 SHALL be ignored; no queueing.
REQ-020 When gate=1, phase <= phase + inc every cycle, mod 2^PHASE_W, with no phase reset on an inc change.
REQ-021 When gate=0, phase SHALL be forced to 0 every cycle; a rising edge of gate therefore starts at phase 0.
REQ-022 Stage 1 (registered) SHALL form raw from phase and mode, with A = 2^(OUT_W-1)-1:
 - SQUARE: phase MSB 0 -> +A, 1 -> -A.
 - SAW: top OUT_W bits of phase, MSB inverted (-2^(OUT_W-1) .. A).
 - TRIANGLE: t = phase bits [PHASE_W-2 -: OUT_W]; MSB 0 -> t - 2^(OUT_W-1); MSB 1 -> A - t.
 - PULSE: phase[PHASE_W-1 -: 7] < duty -> +A, else -A; duty 0 gives constant -A.
REQ-023 Stage 2 (registered) SHALL compute value = (raw * volume) >>> 7 as a signed multiply with an arithmetic shift, truncated to OUT_W.
REQ-024 value SHALL be 0 when gate was 0 at the corresponding stage-1 cycle; latency from phase/mode/gate to value is 2 cycles; volume is sampled at stage 2.
REQ-025 A mode, duty or volume change SHALL take effect without glitch states and without affecting phase.

Reset
REQ-026 On reset: phase=0, inc=0, FSM=IDLE, busy=0, stage-1 raw=0, value=0.
REQ-027 Reset in DIV/LOAD SHALL abort the conversion; inc stays 0 until a new note_valid.
REQ-028 Reset takes priority over note_valid and gate in the same cycle.

Structure
REQ-029 Package osc_pkg: wave mode enum, TOP_OCTAVE=10 and SEMITONES=12 constants, elaboration-time TOP_INC function.
REQ-030 Sub-module note_to_inc SHALL contain the converter FSM (REQ-015..019), with outputs inc and busy.
REQ-031 midi_oscillator SHALL contain the phase accumulator and the two-stage waveform/scale pipeline.

Verification
REQ-032 Reset, then note=69 with note_valid and defaults: busy high 7 cycles, inc=37795, SQUARE period about 113638 cycles.
REQ-033 SQUARE, volume=127, gate=1: value alternates between 8323071 and -8323072; volume=0 -> value 0.
REQ-034 note_valid again during busy (note 127 after note 69): second request ignored, final inc = TOP_INC[9]>>5.
REQ-035 PULSE, duty=0 -> constant -scaled A; duty=32 -> high for 25% of period within ±1 cycle.
REQ-036 gate 1->0 -> value 0 two cycles later; gate 0->1 -> phase restarts at 0 (SAW first sample -2^23 scaled).
REQ-037 Reset asserted mid-DIV for note 100 -> busy=0 next cycle, inc=0, value=0.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared constants, waveform mode encoding and the top-octave increment table
// generator for the MIDI oscillator.
package osc_pkg;

  localparam int unsigned TOP_OCTAVE = 10;
  localparam int unsigned SEMITONES  = 12;
  localparam int unsigned NOTE_W     = 7;
  localparam int unsigned SEMI_W     = 4;
  localparam int unsigned OCT_W      = 4;
  localparam int unsigned MODE_W     = 2;
  localparam int unsigned LEVEL_W    = 7;

  typedef enum logic [MODE_W-1:0] {
    WAVE_SQUARE   = 2'd0,
    WAVE_SAW      = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_PULSE    = 2'd3
  } wave_mode_e;

  // Phase step for semitone 'semi' of the top octave (MIDI 120+semi), rounded.
  function automatic logic [63:0] top_inc(input int unsigned semi,
                                          input int unsigned phase_w,
                                          input int unsigned clk_hz);
    real freq;
    real steps;
    freq  = 440.0 * (2.0 ** ((real'(TOP_OCTAVE * SEMITONES) + real'(semi) - 69.0) / 12.0));
    steps = freq * (2.0 ** real'(phase_w)) / real'(clk_hz);
    return 64'(longint'($floor(steps + 0.5)));
  endfunction

endpackage

// File: rtl/midi_oscillator_if.sv
// Control and sample bus of the MIDI oscillator.
interface midi_oscillator_if import osc_pkg::*; #(
  parameter int unsigned OUT_W = 24
) ();

  logic                     note_valid;
  logic [NOTE_W-1:0]        note;
  logic                     gate;
  logic [LEVEL_W-1:0]       volume;
  logic [MODE_W-1:0]        mode;
  logic [LEVEL_W-1:0]       duty;
  logic                     busy;
  logic signed [OUT_W-1:0]  value;

  modport master (
    output note_valid, note, gate, volume, mode, duty,
    input  busy, value
  );

  modport slave (
    input  note_valid, note, gate, volume, mode, duty,
    output busy, value
  );

endinterface

// File: rtl/note_to_inc.sv
// Converts a MIDI note number into a phase increment by repeated subtraction
// of 12 (octave count) followed by a shift of the top-octave table entry.
module note_to_inc import osc_pkg::*; #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_valid_i,
  input  logic [NOTE_W-1:0]  note_i,
  output logic [PHASE_W-1:0] inc_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  state_e              state_q;
  logic [OCT_W-1:0]    oct_q;
  logic [NOTE_W-1:0]   rem_q;
  logic [PHASE_W-1:0]  inc_q;
  logic                busy_q;
  logic [PHASE_W-1:0]  top_tbl [SEMITONES];

  // Top-octave increments, fixed at elaboration.
  for (genvar s = 0; s < SEMITONES; s++) begin : g_top_inc
    localparam logic [63:0] TOP_INC_S = top_inc(s, PHASE_W, CLK_HZ);
    assign top_tbl[s] = PHASE_W'(TOP_INC_S);
  end

  // Converter FSM; requests arriving outside IDLE are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      oct_q   <= '0;
      rem_q   <= '0;
      inc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (note_valid_i) begin
            state_q <= ST_DIV;
            oct_q   <= '0;
            rem_q   <= note_i;
            busy_q  <= 1'b1;
          end
        end
        ST_DIV: begin
          if (rem_q >= NOTE_W'(SEMITONES)) begin
            rem_q <= rem_q - NOTE_W'(SEMITONES);
            oct_q <= oct_q + OCT_W'(1);
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          inc_q   <= top_tbl[rem_q[SEMI_W-1:0]] >> (OCT_W'(TOP_OCTAVE) - oct_q);
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inc_o  = inc_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/midi_oscillator.sv
// MIDI note oscillator: phase accumulator followed by a registered waveform
// shaper and a registered volume scaler.
module midi_oscillator import osc_pkg::*; #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OUT_W   = 24
) (
  input  logic            clk,
  input  logic            reset,
  midi_oscillator_if.slave bus
);

  localparam int unsigned PROD_W = OUT_W + 8;
  localparam logic [OUT_W-1:0]        HALF  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        AMP_U = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] AMP   = $signed(AMP_U);

  logic [PHASE_W-1:0]        inc_w;
  logic                      busy_w;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic [OUT_W-1:0]          top_bits_w, tri_bits_w;
  logic signed [OUT_W-1:0]   raw_q, raw_d;
  logic                      gate1_q;
  logic signed [PROD_W-1:0]  prod_w;
  logic signed [OUT_W-1:0]   value_q, value_d;

  note_to_inc #(
    .CLK_HZ  (CLK_HZ),
    .PHASE_W (PHASE_W)
  ) u_conv (
    .clk          (clk),
    .reset        (reset),
    .note_valid_i (bus.note_valid),
    .note_i       (bus.note),
    .inc_o        (inc_w),
    .busy_o       (busy_w)
  );

  // Accumulate while gated, otherwise park at phase 0.
  always_comb begin
    phase_d = '0;
    if (bus.gate) phase_d = phase_q + inc_w;
  end

  assign top_bits_w = phase_q[PHASE_W-1 -: OUT_W];
  assign tri_bits_w = phase_q[PHASE_W-2 -: OUT_W];

  // Stage 1: shape the current phase into a full-scale signed sample.
  always_comb begin
    raw_d = '0;
    unique case (wave_mode_e'(bus.mode))
      WAVE_SQUARE:   raw_d = phase_q[PHASE_W-1] ? -AMP : AMP;
      WAVE_SAW:      raw_d = $signed(top_bits_w ^ HALF);
      WAVE_TRIANGLE: raw_d = phase_q[PHASE_W-1] ? $signed(AMP_U - tri_bits_w)
                                                : $signed(tri_bits_w ^ HALF);
      WAVE_PULSE:    raw_d = (phase_q[PHASE_W-1 -: LEVEL_W] < bus.duty) ? AMP : -AMP;
    endcase
  end

  assign prod_w = PROD_W'(raw_q) * PROD_W'($signed({1'b0, bus.volume}));

  // Stage 2: scale by volume/128 with floor rounding; silent when ungated.
  always_comb begin
    value_d = '0;
    if (gate1_q) value_d = OUT_W'(prod_w >>> 7);
  end

  // Phase and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      raw_q   <= '0;
      gate1_q <= 1'b0;
      value_q <= '0;
    end else begin
      phase_q <= phase_d;
      raw_q   <= raw_d;
      gate1_q <= bus.gate;
      value_q <= value_d;
    end
  end

  assign bus.busy  = busy_w;
  assign bus.value = value_q;

endmodule

// File: tb/tb_midi_oscillator.sv
// Randomized bench for midi_oscillator against an arithmetic reference model.
module tb_midi_oscillator;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned PHASE_W = 32;
  localparam int unsigned OUT_W   = 24;
  localparam longint AMP   = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint HALFO = 64'sd1 <<< (OUT_W - 1);
  localparam longint PMOD  = 64'sd1 <<< PHASE_W;
  localparam longint PHALF = 64'sd1 <<< (PHASE_W - 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  midi_oscillator_if #(.OUT_W(OUT_W)) bus ();

  midi_oscillator #(
    .CLK_HZ  (CLK_HZ),
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  longint m_phase, m_inc, m_pending, m_raw, m_value;
  int     m_busy;
  bit     m_g1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint top_inc(input int s);
    real f;
    f = 440.0 * (2.0 ** ((51.0 + s) / 12.0));
    return longint'($floor(f * (2.0 ** PHASE_W) / CLK_HZ + 0.5));
  endfunction

  function automatic longint exp_inc(input int n);
    return top_inc(n % 12) >> (10 - n / 12);
  endfunction

  function automatic longint wave(input longint ph, input int md, input int dt);
    longint t;
    case (md)
      0: return (ph < PHALF) ? AMP : -AMP;
      1: return ph / (64'sd1 <<< (PHASE_W - OUT_W)) - HALFO;
      2: begin
        t = (ph % PHALF) / (64'sd1 <<< (PHASE_W - 1 - OUT_W));
        return (ph < PHALF) ? t - HALFO : AMP - t;
      end
      default: return ((ph / (64'sd1 <<< (PHASE_W - 7))) < dt) ? AMP : -AMP;
    endcase
  endfunction

  function automatic longint scale(input longint raw, input int vol);
    longint p, q;
    p = raw * vol;
    q = p / 128;
    if ((p % 128) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_inc = 0; m_pending = 0; m_raw = 0; m_value = 0;
      m_busy = 0; m_g1 = 1'b0;
    end else begin
      m_value = m_g1 ? scale(m_raw, int'(bus.volume)) : 0;
      m_raw   = wave(m_phase, int'(bus.mode), int'(bus.duty));
      m_g1    = bus.gate;
      m_phase = bus.gate ? (m_phase + m_inc) % PMOD : 0;
      if (m_busy == 0 && bus.note_valid) begin
        m_busy    = int'(bus.note) / 12 + 2;
        m_pending = exp_inc(int'(bus.note));
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_inc = m_pending;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check("value", longint'(bus.value), m_value);
    check("busy", longint'(bus.busy), longint'(m_busy > 0));
    check("inc", longint'(dut.inc_w), m_inc);
  endtask

  task automatic strobe(input int n);
    bus.note_valid = 1'b1;
    bus.note = 7'(n);
    tick();
    bus.note_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n, hi, per;
    bit seen_lo;
    reset = 1'b1;
    bus.note_valid = 1'b0; bus.note = '0; bus.gate = 1'b0;
    bus.volume = '0; bus.mode = '0; bus.duty = '0;
    run(2);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_inc", longint'(dut.inc_w), 0);
    check("rst_value", longint'(bus.value), 0);
    reset = 1'b0;

    // A4: busy length and increment
    strobe(69);
    n = 0;
    while (bus.busy && n < 20) begin n++; tick(); end
    check("busy_len_69", n, 7);
    check("inc_69", longint'(dut.inc_w), 37795);

    // SQUARE full scale, then mute
    bus.mode = 2'd0; bus.volume = 7'd127; bus.gate = 1'b1;
    run(2);
    check("sq_hi", longint'(bus.value), 8323071);
    bus.volume = 7'd0;
    run(2);
    check("sq_vol0", longint'(bus.value), 0);
    bus.volume = 7'd127;
    strobe(127);
    run(13);
    seen_lo = 1'b0; n = 0;
    while (!seen_lo && n < 5000) begin
      n++; tick();
      if (longint'(bus.value) == -8323072) seen_lo = 1'b1;
    end
    check("sq_lo_seen", longint'(seen_lo), 1);

    // Request during busy is dropped
    bus.gate = 1'b0;
    strobe(69);
    tick();
    strobe(127);
    run(15);
    check("collide_inc", longint'(dut.inc_w), top_inc(9) >> 5);

    // PULSE duty 0 and 25 %
    strobe(127);
    run(13);
    bus.mode = 2'd3; bus.duty = 7'd0; bus.gate = 1'b1;
    run(100);
    check("pulse_duty0", longint'(bus.value), -8323072);
    bus.gate = 1'b0; bus.duty = 7'd32;
    run(2);
    bus.gate = 1'b1;
    run(2);
    per = int'(PMOD / exp_inc(127));
    hi = 0;
    for (int i = 0; i < per; i++) begin
      if (bus.value > 0) hi++;
      tick();
    end
    check("pulse_25pct", longint'((hi >= per / 4 - 1) && (hi <= per / 4 + 1)), 1);

    // Gate fall silences, gate rise restarts at phase 0
    bus.gate = 1'b0;
    run(2);
    check("gate_off", longint'(bus.value), 0);
    bus.mode = 2'd1;
    bus.gate = 1'b1;
    run(2);
    check("saw_first", longint'(bus.value), -8323072);

    // Reset during conversion
    strobe(100);
    tick();
    reset = 1'b1;
    tick();
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_inc", longint'(dut.inc_w), 0);
    check("abort_value", longint'(bus.value), 0);
    reset = 1'b0;

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      bus.mode   = 2'($urandom_range(3));
      bus.volume = 7'($urandom_range(127));
      bus.duty   = 7'($urandom_range(127));
      run(14);
      strobe(int'($urandom_range(127, 60)));
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(199) == 0) bus.gate = ~bus.gate;
        bus.note_valid = ($urandom_range(49) == 0);
        bus.note = 7'($urandom_range(127));
        if ($urandom_range(99) == 0) bus.mode = 2'($urandom_range(3));
        if ($urandom_range(99) == 0) bus.volume = 7'($urandom_range(127));
        if ($urandom_range(99) == 0) bus.duty = 7'($urandom_range(127));
        reset = ($urandom_range(1999) == 0);
        tick();
      end
      bus.note_valid = 1'b0;
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
